id_ex_pipe: RTL and testbench

Parametrised decode-to-execute pipeline register with a valid/ready handshake, an optional 2-entry skid buffer, and synchronous flush.
It sits between the decode and execute stages and carries the ALU op, selector, operands, destination and link/delay-slot side information.
It lets execute stall without combinational backpressure into decode and lets control squash the in-flight instruction.
It also counts execute-side stall cycles for performance monitoring.

---
 rtl/id_ex_pipe_pkg.sv | 23 ++
 rtl/id_ex_pipe_if.sv | 31 +++
 rtl/id_ex_payload_reg.sv | 44 ++++
 rtl/id_ex_pipe.sv | 173 +++++++++++++++++
 tb/tb_id_ex_pipe.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared encodings for the decode-to-execute pipeline register:
// NOP payload field values, control levels and the occupancy state encoding.
package id_ex_pipe_pkg;

   // NOP payload fields (default widths; the top resizes them to its parameters)
   localparam logic [7:0]  EXE_NOP_OP        = 8'h00;
   localparam logic [2:0]  EXE_RES_NOP       = 3'b000;
   localparam logic [4:0]  NOP_REG_ADDR      = 5'b00000;
   localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
   localparam logic        WRITE_DISABLE     = 1'b0;
   localparam logic        NOT_IN_DELAY_SLOT = 1'b0;

   // Reset level of the active-high reset
   localparam logic        RST_ENABLE        = 1'b1;

   // Occupancy of the pipeline register
   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // nothing held
      FULL  = 2'd1,   // main entry valid
      SKID  = 2'd2    // main and skid entries valid
   } pipe_state_e;

endpackage : id_ex_pipe_pkg

// File: rtl/id_ex_pipe_if.sv
// Valid/ready bus carrying one decoded instruction between pipeline stages.
// master drives valid and payload; slave drives ready.
interface id_ex_pipe_if #(
   parameter int ALUOP_W   = 8,
   parameter int ALUSEL_W  = 3,
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5
);

   logic                 valid;
   logic                 ready;
   logic [ALUOP_W-1:0]   aluop;
   logic [ALUSEL_W-1:0]  alusel;
   logic [DATA_W-1:0]    reg1;
   logic [DATA_W-1:0]    reg2;
   logic [REGADDR_W-1:0] wd;
   logic                 wreg;
   logic [DATA_W-1:0]    link_addr;
   logic                 in_delayslot;

   modport master (
      output valid, aluop, alusel, reg1, reg2, wd, wreg, link_addr, in_delayslot,
      input  ready
   );

   modport slave (
      input  valid, aluop, alusel, reg1, reg2, wd, wreg, link_addr, in_delayslot,
      output ready
   );

endinterface : id_ex_pipe_if

// File: rtl/id_ex_payload_reg.sv
// Width-generic payload register: load, synchronous clear-to-NOP and
// asynchronous reset to NOP. Clear wins over load.
module id_ex_payload_reg
   import id_ex_pipe_pkg::*;
#(
   parameter int           W   = 1,
   parameter logic [W-1:0] NOP = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_d;
   logic [W-1:0] data_q;

   // Next payload: clear to NOP, else load, else hold
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves data_d unassigned (no latch).
      data_d = data_q;
      if (clear) begin
         data_d = NOP;
      end else if (load) begin
         data_d = d;
      end
   end

   // Payload storage, reset to NOP so an empty stage never presents a write
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: payload registers are reset too, not just control; outputs must read NOP straight out of reset.
      if (rst == RST_ENABLE) begin
         data_q <= NOP;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule : id_ex_payload_reg

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a saturating stall counter.
module id_ex_pipe
   import id_ex_pipe_pkg::*;
#(
   parameter int ALUOP_W   = 8,
   parameter int ALUSEL_W  = 3,
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5,
   parameter int SKID_EN   = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   id_ex_pipe_if.slave       id_bus,
   id_ex_pipe_if.master      ex_bus,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PL_W = ALUOP_W + ALUSEL_W + 3 * DATA_W + REGADDR_W + 2;

   localparam logic [PL_W-1:0] PL_NOP = {
      ALUOP_W'(EXE_NOP_OP),
      ALUSEL_W'(EXE_RES_NOP),
      DATA_W'(ZERO_WORD),
      DATA_W'(ZERO_WORD),
      REGADDR_W'(NOP_REG_ADDR),
      WRITE_DISABLE,
      DATA_W'(ZERO_WORD),
      NOT_IN_DELAY_SLOT
   };

   pipe_state_e      state_d, state_q;
   logic [CNT_W-1:0] stall_d, stall_q;

   logic [PL_W-1:0]  id_pl;
   logic [PL_W-1:0]  main_q;
   logic [PL_W-1:0]  main_in;
   logic [PL_W-1:0]  skid_q;

   logic             id_ready;
   logic             ex_valid;
   logic             acc;
   logic             pop;

   logic             main_ld;
   logic             main_from_skid;
   logic             main_clr;
   logic             skid_ld;
   logic             skid_clr;

   assign id_pl = {id_bus.aluop, id_bus.alusel, id_bus.reg1, id_bus.reg2,
                   id_bus.wd, id_bus.wreg, id_bus.link_addr, id_bus.in_delayslot};

   // With the skid buffer ready depends on state only, so no ex_ready path reaches decode
   if (SKID_EN != 0) begin : g_rdy_skid
      assign id_ready = (state_q != SKID);
   end else begin : g_rdy_comb
      assign id_ready = (state_q == EMPTY) | ex_bus.ready;
   end

   assign ex_valid = (state_q != EMPTY);
   assign acc      = id_bus.valid & id_ready;
   assign pop      = ex_valid & ex_bus.ready;

   // Next occupancy and entry load/clear strobes; flush overrides everything
   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      main_clr       = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         state_d  = EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  main_ld = 1'b1;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (acc && pop) begin
                  main_ld = 1'b1;
               end else if (acc && (SKID_EN != 0)) begin
                  skid_ld = 1'b1;
                  state_d = SKID;
               end else if (pop) begin
                  main_clr = 1'b1;
                  state_d  = EMPTY;
               end
            end
            SKID: begin
               if (pop) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_d        = FULL;
               end
            end
            default: begin
               state_d  = EMPTY;
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   // Saturating count of cycles where execute holds off a valid payload
   always_comb begin
      stall_d = stall_q;
      if (ex_valid && !ex_bus.ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // Occupancy FSM and stall counter; only rst clears the counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q <= EMPTY;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   assign main_in = main_from_skid ? skid_q : id_pl;

   id_ex_payload_reg #(
      .W   (PL_W),
      .NOP (PL_NOP)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_ld),
      .clear (main_clr),
      .d     (main_in),
      .q     (main_q)
   );

   // Second entry exists only when the skid buffer is enabled
   if (SKID_EN != 0) begin : g_skid
      id_ex_payload_reg #(
         .W   (PL_W),
         .NOP (PL_NOP)
      ) u_skid (
         .clk   (clk),
         .rst   (rst),
         .load  (skid_ld),
         .clear (skid_clr),
         .d     (id_pl),
         .q     (skid_q)
      );
   end else begin : g_no_skid
      logic unused_skid;
      assign skid_q      = PL_NOP;
      assign unused_skid = skid_ld | skid_clr;
   end

   assign id_bus.ready = id_ready;
   assign ex_bus.valid = ex_valid;
   assign {ex_bus.aluop, ex_bus.alusel, ex_bus.reg1, ex_bus.reg2,
           ex_bus.wd, ex_bus.wreg, ex_bus.link_addr, ex_bus.in_delayslot} = main_q;
   assign stall_cnt    = stall_q;

endmodule : id_ex_pipe

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench: two instances (skid buffer with 4-bit counter, and
// single register with 16-bit counter) driven with the same stimulus and
// compared every cycle against a FIFO-queue reference model.
module tb_id_ex_pipe;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] link_addr;
      logic        in_ds;
   } pl_t;

   localparam int MAX_A = 15;
   localparam int MAX_B = 65535;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [3:0]  stall_a;
   logic [15:0] stall_b;

   always #5 clk = ~clk;

   id_ex_pipe_if ida ();
   id_ex_pipe_if exa ();
   id_ex_pipe_if idb ();
   id_ex_pipe_if exb ();

   id_ex_pipe #(.SKID_EN(1), .CNT_W(4)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .id_bus    (ida),
      .ex_bus    (exa),
      .stall_cnt (stall_a)
   );

   id_ex_pipe #(.SKID_EN(0), .CNT_W(16)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .id_bus    (idb),
      .ex_bus    (exb),
      .stall_cnt (stall_b)
   );

   int  checks = 0;
   int  errors = 0;

   // Reference model: each stage is a FIFO of held instructions plus a stall count
   pl_t qa[$];
   pl_t qb[$];
   int  cnt_a;
   int  cnt_b;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic pl_t obs_a();
      return {exa.aluop, exa.alusel, exa.reg1, exa.reg2, exa.wd, exa.wreg, exa.link_addr, exa.in_delayslot};
   endfunction

   function automatic pl_t obs_b();
      return {exb.aluop, exb.alusel, exb.reg1, exb.reg2, exb.wd, exb.wreg, exb.link_addr, exb.in_delayslot};
   endfunction

   function automatic pl_t rnd_pl();
      pl_t p;
      p.aluop     = 8'($urandom);
      p.alusel    = 3'($urandom);
      p.reg1      = $urandom;
      p.reg2      = $urandom;
      p.wd        = 5'($urandom);
      p.wreg      = 1'($urandom);
      p.link_addr = $urandom;
      p.in_ds     = 1'($urandom);
      return p;
   endfunction

   function automatic pl_t mk(input logic [31:0] r1, input logic [4:0] wd, input logic wreg);
      pl_t p;
      p      = rnd_pl();
      p.reg1 = r1;
      p.wd   = wd;
      p.wreg = wreg;
      return p;
   endfunction

   task automatic drive(input logic v, input pl_t p, input logic er, input logic fl);
      {ida.aluop, ida.alusel, ida.reg1, ida.reg2, ida.wd, ida.wreg, ida.link_addr, ida.in_delayslot} = p;
      {idb.aluop, idb.alusel, idb.reg1, idb.reg2, idb.wd, idb.wreg, idb.link_addr, idb.in_delayslot} = p;
      ida.valid = v;
      idb.valid = v;
      exa.ready = er;
      exb.ready = er;
      flush     = fl;
   endtask

   // One cycle: drive at the falling edge, compare, then advance the model to the next rising edge
   task automatic step(input logic v, input pl_t p, input logic er, input logic fl);
      pl_t ea, eb;
      bit  rdy_a, rdy_b;
      @(negedge clk);
      drive(v, p, er, fl);
      #1;
      ea    = (qa.size() != 0) ? qa[0] : pl_t'(0);
      eb    = (qb.size() != 0) ? qb[0] : pl_t'(0);
      rdy_a = (qa.size() < 2);
      rdy_b = (qb.size() == 0) || er;
      check("a_valid", exa.valid, qa.size() != 0);
      check("a_payload", obs_a(), ea);
      check("a_ready", ida.ready, rdy_a);
      check("a_stall", stall_a, cnt_a);
      check("b_valid", exb.valid, qb.size() != 0);
      check("b_payload", obs_b(), eb);
      check("b_ready", idb.ready, rdy_b);
      check("b_stall", stall_b, cnt_b);
      if (qa.size() != 0 && !er && cnt_a < MAX_A) cnt_a++;
      if (qb.size() != 0 && !er && cnt_b < MAX_B) cnt_b++;
      if (fl) begin
         qa.delete();
         qb.delete();
      end else begin
         if (qa.size() != 0 && er) void'(qa.pop_front());
         if (qb.size() != 0 && er) void'(qb.pop_front());
         if (v && rdy_a) qa.push_back(p);
         if (v && rdy_b) qb.push_back(p);
      end
   endtask

   initial begin
      pl_t idle;
      idle  = '0;
      cnt_a = 0;
      cnt_b = 0;

      // Reset state
      rst = 1'b1;
      drive(1'b0, idle, 1'b0, 1'b0);
      #2;
      check("rst_a_valid", exa.valid, 1'b0);
      check("rst_a_payload", obs_a(), '0);
      check("rst_a_ready", ida.ready, 1'b1);
      check("rst_a_stall", stall_a, '0);
      check("rst_b_valid", exb.valid, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Streaming: reg1 = 1..4 back to back with execute always ready
      for (int i = 1; i <= 4; i++) step(1'b1, mk(i, 5'(i), 1'b1), 1'b1, 1'b0);
      step(1'b0, idle, 1'b1, 1'b0);
      check("stream_stall", stall_a, '0);
      step(1'b0, idle, 1'b1, 1'b0);

      // Skid fill: A (wd=5) then B (wd=6) while execute stalls
      step(1'b1, mk(32'hA, 5'd5, 1'b1), 1'b0, 1'b0);
      step(1'b1, mk(32'hB, 5'd6, 1'b1), 1'b0, 1'b0);
      step(1'b0, idle, 1'b0, 1'b0);
      check("skid_ready_low", ida.ready, 1'b0);
      check("skid_hold_wd", exa.wd, 5'd5);
      step(1'b0, idle, 1'b0, 1'b0);
      check("skid_hold_wd2", exa.wd, 5'd5);
      step(1'b0, idle, 1'b1, 1'b0);
      step(1'b0, idle, 1'b1, 1'b0);
      check("skid_second_wd", exa.wd, 5'd6);
      check("skid_ready_back", ida.ready, 1'b1);
      step(1'b0, idle, 1'b1, 1'b0);

      // Flush with a full skid buffer and a competing push of wd=7
      step(1'b1, mk(32'h11, 5'd3, 1'b1), 1'b0, 1'b0);
      step(1'b1, mk(32'h22, 5'd4, 1'b1), 1'b0, 1'b0);
      step(1'b1, mk(32'h77, 5'd7, 1'b1), 1'b0, 1'b1);
      step(1'b0, idle, 1'b0, 1'b0);
      check("flush_valid", exa.valid, 1'b0);
      check("flush_wreg", exa.wreg, 1'b0);
      check("flush_wd", exa.wd, 5'd0);
      repeat (3) step(1'b0, idle, 1'b1, 1'b0);

      // Stall counter saturation, then a flush that must not clear it
      step(1'b1, mk(32'h33, 5'd9, 1'b1), 1'b0, 1'b0);
      repeat (20) step(1'b0, idle, 1'b0, 1'b0);
      check("sat_value", stall_a, 4'd15);
      step(1'b0, idle, 1'b0, 1'b1);
      step(1'b0, idle, 1'b0, 1'b0);
      check("sat_after_flush", stall_a, 4'd15);

      // Asynchronous reset between edges while FULL with reg1=DEADBEEF
      step(1'b1, mk(32'hDEADBEEF, 5'd1, 1'b1), 1'b0, 1'b0);
      @(posedge clk);
      #2;
      check("pre_rst_reg1", exa.reg1, 32'hDEADBEEF);
      rst = 1'b1;
      drive(1'b0, idle, 1'b0, 1'b0);
      #1;
      check("arst_valid", exa.valid, 1'b0);
      check("arst_reg1", exa.reg1, 32'h0);
      check("arst_stall", stall_a, '0);
      check("arst_ready", ida.ready, 1'b1);
      check("arst_b_reg1", exb.reg1, 32'h0);
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
      #1;
      rst = 1'b0;

      // Single-register variant: ready follows ex_ready combinationally
      step(1'b1, mk(32'h1, 5'd31, 1'b1), 1'b0, 1'b0);
      step(1'b1, mk(32'h2, 5'd31, 1'b1), 1'b0, 1'b0);
      check("b_ready_stalled", idb.ready, 1'b0);
      step(1'b1, mk(32'h2, 5'd31, 1'b1), 1'b1, 1'b0);
      check("b_ready_comb", idb.ready, 1'b1);
      step(1'b1, mk(32'h3, 5'd31, 1'b1), 1'b1, 1'b0);
      check("b_b2b_wd", exb.wd, 5'd31);
      check("b_b2b_wreg", exb.wreg, 1'b1);
      step(1'b0, idle, 1'b1, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), rnd_pl(), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 19) == 0));
      end
      step(1'b0, idle, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_id_ex_pipe
